// File: rtl/rggen_register_access_controller.sv
`default_nettype none
// ============================================================================
//  Module   : rggen_register_access_controller
//  Purpose  : Accepts one host request at a time and broadcasts it to the
//             register instances. It then collects the hit/ready response,
//             applying unmapped, write-data and timeout rules, and holds the
//             response until the host takes it.
//  Revision : 1.0 - initial release
// ============================================================================
module rggen_register_access_controller #(
   parameter int ADDRESS_WIDTH  = 8,
   parameter int BUS_WIDTH      = 32,
   parameter int REGISTERS      = 1,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int ERROR_STATUS   = 0
)(
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_req_valid,
   output logic                           o_req_ready,
   input  logic [ADDRESS_WIDTH-1:0]       i_req_address,
   input  logic                           i_req_write,
   input  logic [BUS_WIDTH-1:0]           i_req_data,
   input  logic [BUS_WIDTH-1:0]           i_req_strobe,
   output logic                           o_rsp_valid,
   input  logic                           i_rsp_ready,
   output logic [1:0]                     o_rsp_status,
   output logic [BUS_WIDTH-1:0]           o_rsp_data,
   output logic                           o_reg_valid,
   output logic                           o_reg_write,
   output logic [ADDRESS_WIDTH-1:0]       o_reg_address,
   output logic [BUS_WIDTH-1:0]           o_reg_write_data,
   output logic [BUS_WIDTH-1:0]           o_reg_strobe,
   input  logic [REGISTERS-1:0]           i_reg_active,
   input  logic [REGISTERS-1:0]           i_reg_ready,
   input  logic [2*REGISTERS-1:0]         i_reg_status,
   input  logic [BUS_WIDTH*REGISTERS-1:0] i_reg_read_data
);

   // Byte-lane address bits dropped so the broadcast address is bus-aligned.
   localparam int c_LSB = $clog2(BUS_WIDTH / 8);
   // With the timeout disabled the counter width is held at a minimum of 1 bit.
   localparam int c_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [ADDRESS_WIDTH-1:0] c_ADDR_MASK = {ADDRESS_WIDTH{1'b1}} << c_LSB;
   localparam logic [1:0] c_STATUS_OKAY     = 2'b00;
   localparam logic [1:0] c_STATUS_SLVERR   = 2'b10;
   localparam logic [1:0] c_UNMAPPED_STATUS = (ERROR_STATUS != 0) ? c_STATUS_SLVERR : c_STATUS_OKAY;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY    = 2'd1,
      ST_RESPOND = 2'd2
   } state_t;

   state_t                   r_state;
   state_t                   w_state_next;
   logic                     r_reg_valid;
   logic                     r_reg_write;
   logic [ADDRESS_WIDTH-1:0] r_reg_address;
   logic [BUS_WIDTH-1:0]     r_reg_write_data;
   logic [BUS_WIDTH-1:0]     r_reg_strobe;
   logic [1:0]               r_rsp_status;
   logic [BUS_WIDTH-1:0]     r_rsp_data;

   logic                     w_accept;
   logic [REGISTERS-1:0]     w_hit;
   logic                     w_any_active;
   logic                     w_any_hit;
   logic                     w_timeout;
   logic                     w_done;
   logic [1:0]               w_hit_status;
   logic [BUS_WIDTH-1:0]     w_hit_data;
   logic [1:0]               w_done_status;
   logic [BUS_WIDTH-1:0]     w_done_data;

   assign w_accept     = i_req_valid && (r_state == ST_IDLE);
   assign w_hit        = i_reg_active & i_reg_ready;
   assign w_any_active = |i_reg_active;
   assign w_any_hit    = |w_hit;
   // Unmapped accesses finish at once; hits finish on ready; otherwise wait for the timeout.
   assign w_done       = (r_state == ST_BUSY) && (!w_any_active || w_any_hit || w_timeout);

   generate
      if (TIMEOUT_CYCLES > 0) begin : g_timeout
         logic [c_CNT_W-1:0] r_count;

         // Count BUSY cycles that end without completion; restart on every accept.
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               r_count <= '0;
            end else if (w_accept) begin
               r_count <= '0;
            end else if ((r_state == ST_BUSY) && !w_done) begin
               r_count <= r_count + c_CNT_W'(1);
            end
         end

         // The cycle in which the limit is reached is the last BUSY cycle.
         assign w_timeout = (r_count == c_CNT_W'(TIMEOUT_CYCLES - 1));
      end else begin : g_no_timeout
         assign w_timeout = 1'b0;
      end
   endgenerate

   // OR together the responses of every register that is both active and ready.
   always_comb begin
      w_hit_status = '0;
      w_hit_data   = '0;
      for (int k = 0; k < REGISTERS; k++) begin
         if (w_hit[k]) begin
            w_hit_status = w_hit_status | i_reg_status[2*k +: 2];
            w_hit_data   = w_hit_data | i_reg_read_data[BUS_WIDTH*k +: BUS_WIDTH];
         end
      end
   end

   // Choose the completion response; a ready takes precedence over the timeout.
   always_comb begin
      w_done_status = c_STATUS_OKAY;
      w_done_data   = '0;
      if (!w_any_active) begin
         w_done_status = c_UNMAPPED_STATUS;
      end else if (w_any_hit) begin
         w_done_status = w_hit_status;
         w_done_data   = r_reg_write ? '0 : w_hit_data;
      end else begin
         w_done_status = c_STATUS_SLVERR;
      end
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: IDLE -> BUSY on accept, BUSY -> RESPOND on completion, RESPOND -> IDLE on handshake.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:    if (i_req_valid) w_state_next = ST_BUSY;
         ST_BUSY:    if (w_done)      w_state_next = ST_RESPOND;
         ST_RESPOND: if (i_rsp_ready) w_state_next = ST_IDLE;
         default:                     w_state_next = ST_IDLE;
      endcase
   end

   // Capture the request for broadcast and register the response; clear the response once it is taken.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_reg_valid      <= 1'b0;
         r_reg_write      <= 1'b0;
         r_reg_address    <= '0;
         r_reg_write_data <= '0;
         r_reg_strobe     <= '0;
         r_rsp_status     <= '0;
         r_rsp_data       <= '0;
      end else begin
         if (w_accept) begin
            r_reg_valid      <= 1'b1;
            r_reg_write      <= i_req_write;
            r_reg_address    <= i_req_address & c_ADDR_MASK;
            r_reg_write_data <= i_req_data;
            r_reg_strobe     <= i_req_strobe;
         end else if (w_done) begin
            r_reg_valid      <= 1'b0;
         end
         if (w_done) begin
            r_rsp_status <= w_done_status;
            r_rsp_data   <= w_done_data;
         end else if ((r_state == ST_RESPOND) && i_rsp_ready) begin
            r_rsp_status <= '0;
            r_rsp_data   <= '0;
         end
      end
   end

   assign o_req_ready      = (r_state == ST_IDLE);
   assign o_rsp_valid      = (r_state == ST_RESPOND);
   assign o_rsp_status     = r_rsp_status;
   assign o_rsp_data       = r_rsp_data;
   assign o_reg_valid      = r_reg_valid;
   assign o_reg_write      = r_reg_write;
   assign o_reg_address    = r_reg_address;
   assign o_reg_write_data = r_reg_write_data;
   assign o_reg_strobe     = r_reg_strobe;

`ifndef SYNTHESIS
   // Flag more than one register completing in the same BUSY cycle; the OR result is still used.
   always_ff @(posedge i_clk) begin
      if (!i_rst && (r_state == ST_BUSY)) begin
         assert ($onehot0(w_hit))
         else $error("more than one register active and ready in the same cycle");
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rggen_register_access_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rggen_register_access_controller
//  Purpose  : Randomized and directed bench for the register access controller
//             with a transaction-level expectation model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rggen_register_access_controller;

   localparam int AW = 8;
   localparam int BW = 32;
   localparam int NR = 2;
   localparam int TO = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            req_valid;
   logic            req_write;
   logic [AW-1:0]   req_address;
   logic [BW-1:0]   req_data;
   logic [BW-1:0]   req_strobe;
   logic            rsp_ready;
   logic [NR-1:0]   reg_active;
   logic [NR-1:0]   reg_ready;
   logic [2*NR-1:0] reg_status;
   logic [BW*NR-1:0] reg_read_data;

   logic            req_ready0, rsp_valid0, reg_valid0, reg_write0;
   logic [1:0]      rsp_status0;
   logic [BW-1:0]   rsp_data0, reg_write_data0, reg_strobe0;
   logic [AW-1:0]   reg_address0;
   logic            req_ready1, rsp_valid1, reg_valid1, reg_write1;
   logic [1:0]      rsp_status1;
   logic [BW-1:0]   rsp_data1, reg_write_data1, reg_strobe1;
   logic [AW-1:0]   reg_address1;

   rggen_register_access_controller #(
      .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .REGISTERS(NR), .TIMEOUT_CYCLES(TO), .ERROR_STATUS(0)
   ) dut0 (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid), .o_req_ready(req_ready0), .i_req_address(req_address),
      .i_req_write(req_write), .i_req_data(req_data), .i_req_strobe(req_strobe),
      .o_rsp_valid(rsp_valid0), .i_rsp_ready(rsp_ready), .o_rsp_status(rsp_status0), .o_rsp_data(rsp_data0),
      .o_reg_valid(reg_valid0), .o_reg_write(reg_write0), .o_reg_address(reg_address0),
      .o_reg_write_data(reg_write_data0), .o_reg_strobe(reg_strobe0),
      .i_reg_active(reg_active), .i_reg_ready(reg_ready), .i_reg_status(reg_status),
      .i_reg_read_data(reg_read_data)
   );

   rggen_register_access_controller #(
      .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .REGISTERS(NR), .TIMEOUT_CYCLES(TO), .ERROR_STATUS(1)
   ) dut1 (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid), .o_req_ready(req_ready1), .i_req_address(req_address),
      .i_req_write(req_write), .i_req_data(req_data), .i_req_strobe(req_strobe),
      .o_rsp_valid(rsp_valid1), .i_rsp_ready(rsp_ready), .o_rsp_status(rsp_status1), .o_rsp_data(rsp_data1),
      .o_reg_valid(reg_valid1), .o_reg_write(reg_write1), .o_reg_address(reg_address1),
      .o_reg_write_data(reg_write_data1), .o_reg_strobe(reg_strobe1),
      .i_reg_active(reg_active), .i_reg_ready(reg_ready), .i_reg_status(reg_status),
      .i_reg_read_data(reg_read_data)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Expected outputs for the current cycle, set by the driver from the transaction plan.
   logic          chk_en = 1'b0;
   logic          e_req_ready, e_reg_valid, e_rsp_valid, e_write;
   logic [1:0]    e_status0, e_status1;
   logic [BW-1:0] e_data, e_wdata, e_strobe;
   logic [AW-1:0] e_addr;

   // Observations used by the literal checks.
   int            cyc = 0, acc_cyc = 0, lat = 0, busy_cnt = 0, rsp_cnt = 0;
   logic [1:0]    obs_status0, obs_status1;
   logic [BW-1:0] obs_data;
   logic [AW-1:0] obs_addr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      cyc++;
      if (chk_en) begin
         chk("req_ready", {63'd0, req_ready0}, {63'd0, e_req_ready});
         chk("req_ready_es1", {63'd0, req_ready1}, {63'd0, e_req_ready});
         chk("reg_valid", {63'd0, reg_valid0}, {63'd0, e_reg_valid});
         chk("rsp_valid", {63'd0, rsp_valid0}, {63'd0, e_rsp_valid});
         chk("rsp_valid_es1", {63'd0, rsp_valid1}, {63'd0, e_rsp_valid});
         chk("rsp_status", {62'd0, rsp_status0}, {62'd0, e_status0});
         chk("rsp_status_es1", {62'd0, rsp_status1}, {62'd0, e_status1});
         chk("rsp_data", {32'd0, rsp_data0}, {32'd0, e_data});
         chk("rsp_data_es1", {32'd0, rsp_data1}, {32'd0, e_data});
         if (e_reg_valid) begin
            chk("reg_write", {63'd0, reg_write0}, {63'd0, e_write});
            chk("reg_address", {56'd0, reg_address0}, {56'd0, e_addr});
            chk("reg_write_data", {32'd0, reg_write_data0}, {32'd0, e_wdata});
            chk("reg_strobe", {32'd0, reg_strobe0}, {32'd0, e_strobe});
         end
      end
      if (req_valid && req_ready0) begin
         acc_cyc  = cyc;
         busy_cnt = 0;
         rsp_cnt  = 0;
      end
      if (reg_valid0) begin
         busy_cnt++;
         obs_addr = reg_address0;
      end
      if (rsp_valid0) begin
         if (rsp_cnt == 0) lat = cyc - acc_cyc;
         rsp_cnt++;
         obs_status0 = rsp_status0;
         obs_status1 = rsp_status1;
         obs_data    = rsp_data0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_reg_side();
      reg_active    = 2'($urandom);
      reg_ready     = 2'($urandom);
      reg_status    = 4'($urandom);
      reg_read_data = {$urandom, $urandom};
   endtask

   task automatic set_idle_exp();
      e_req_ready = 1'b1;
      e_reg_valid = 1'b0;
      e_rsp_valid = 1'b0;
      e_status0   = 2'b00;
      e_status1   = 2'b00;
      e_data      = '0;
   endtask

   task automatic set_busy_exp(input logic [AW-1:0] addr, input logic wr,
                               input logic [BW-1:0] wdata, input logic [BW-1:0] strb);
      e_req_ready = 1'b0;
      e_reg_valid = 1'b1;
      e_write     = wr;
      e_addr      = addr & 8'hFC;
      e_wdata     = wdata;
      e_strobe    = strb;
      e_rsp_valid = 1'b0;
      e_status0   = 2'b00;
      e_status1   = 2'b00;
      e_data      = '0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         req_valid   = 1'b0;
         req_address = 8'($urandom);
         rsp_ready   = 1'($urandom);
         rand_reg_side();
         set_idle_exp();
      end
   endtask

   // One full transaction. d = BUSY cycle (1-based) in which the chosen active
   // register reports ready; d > TO means it never does.
   task automatic do_txn(input logic [AW-1:0] addr, input logic wr, input logic [BW-1:0] wdata,
                         input logic [BW-1:0] strb, input logic [NR-1:0] act, input int d,
                         input logic [BW-1:0] hit_data, input logic [1:0] hit_status, input int wait_n);
      int         nb;
      int         k;
      logic [1:0] st0, st1;
      logic [BW-1:0] dat;
      step();
      req_valid   = 1'b1;
      req_address = addr;
      req_write   = wr;
      req_data    = wdata;
      req_strobe  = strb;
      rsp_ready   = 1'($urandom);
      rand_reg_side();
      set_idle_exp();
      if (act == '0) begin
         nb = 1;  st0 = 2'b00; st1 = 2'b10; dat = '0;
      end else if (d <= TO) begin
         nb = d;  st0 = hit_status; st1 = hit_status; dat = wr ? '0 : hit_data;
      end else begin
         nb = TO; st0 = 2'b10; st1 = 2'b10; dat = '0;
      end
      k = act[0] ? 0 : 1;
      if (act == 2'b11 && $urandom_range(1) == 1) k = 1;
      for (int b = 1; b <= nb; b++) begin
         step();
         req_valid     = 1'($urandom);
         req_address   = 8'($urandom);
         req_write     = 1'($urandom);
         req_data      = $urandom;
         req_strobe    = $urandom;
         rsp_ready     = 1'($urandom);
         reg_active    = act;
         reg_status    = 4'($urandom);
         reg_read_data = {$urandom, $urandom};
         reg_ready     = 2'($urandom) & ~act;
         if (act != '0 && b == d) begin
            reg_ready[k]               = 1'b1;
            reg_status[2*k +: 2]       = hit_status;
            reg_read_data[BW*k +: BW]  = hit_data;
         end
         set_busy_exp(addr, wr, wdata, strb);
      end
      for (int r = 0; r <= wait_n; r++) begin
         step();
         req_valid   = 1'($urandom);
         req_address = 8'($urandom);
         rsp_ready   = (r == wait_n);
         rand_reg_side();
         e_req_ready = 1'b0;
         e_reg_valid = 1'b0;
         e_rsp_valid = 1'b1;
         e_status0   = st0;
         e_status1   = st1;
         e_data      = dat;
      end
   endtask

   initial begin
      req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_data = '0; req_strobe = '0;
      rsp_ready = 1'b0; reg_active = '0; reg_ready = '0; reg_status = '0; reg_read_data = '0;
      repeat (3) step();
      set_idle_exp();
      chk_en = 1'b1;
      chk("reset_reg_address", {56'd0, reg_address0}, 64'd0);
      chk("reset_reg_strobe", {32'd0, reg_strobe0}, 64'd0);
      chk("reset_rsp_data", {32'd0, rsp_data0}, 64'd0);
      rst = 1'b0;

      // Read hit on register 1 in the first BUSY cycle.
      do_txn(8'h20, 1'b0, 32'h0, 32'hFFFF_FFFF, 2'b10, 1, 32'hA5A5_0001, 2'b00, 0);
      idle(1);
      chk("read_latency", 64'(lat), 64'd2);
      chk("read_data", {32'd0, obs_data}, 64'hA5A5_0001);
      chk("read_status", {62'd0, obs_status0}, 64'd0);

      // Write: address aligned, read data suppressed.
      do_txn(8'h13, 1'b1, 32'h1234_5678, 32'hFFFF_0000, 2'b01, 1, 32'hDEAD_BEEF, 2'b00, 0);
      idle(1);
      chk("write_address", {56'd0, obs_addr}, 64'h10);
      chk("write_data", {32'd0, obs_data}, 64'd0);
      chk("write_status", {62'd0, obs_status0}, 64'd0);

      // Unmapped access.
      do_txn(8'h40, 1'b0, 32'h0, 32'h0, 2'b00, 1, 32'h5555_5555, 2'b00, 0);
      idle(1);
      chk("unmapped_status_es0", {62'd0, obs_status0}, 64'd0);
      chk("unmapped_status_es1", {62'd0, obs_status1}, 64'd2);
      chk("unmapped_data", {32'd0, obs_data}, 64'd0);
      chk("unmapped_busy_cycles", 64'(busy_cnt), 64'd1);

      // Timeout, then ready arriving in the timeout cycle.
      do_txn(8'h08, 1'b0, 32'h0, 32'h0, 2'b01, 9, 32'h7777_0003, 2'b00, 0);
      idle(1);
      chk("timeout_busy_cycles", 64'(busy_cnt), 64'd4);
      chk("timeout_status", {62'd0, obs_status0}, 64'd2);
      do_txn(8'h08, 1'b0, 32'h0, 32'h0, 2'b01, 4, 32'h7777_0004, 2'b00, 0);
      idle(1);
      chk("ready_at_limit_busy_cycles", 64'(busy_cnt), 64'd4);
      chk("ready_at_limit_status", {62'd0, obs_status0}, 64'd0);
      chk("ready_at_limit_data", {32'd0, obs_data}, 64'h7777_0004);

      // Host back-pressure for 5 cycles.
      do_txn(8'h0C, 1'b0, 32'h0, 32'h0, 2'b10, 2, 32'h0BAD_F00D, 2'b10, 5);
      idle(1);
      chk("backpressure_rsp_cycles", 64'(rsp_cnt), 64'd6);

      // Reset in BUSY abandons the access.
      step();
      req_valid = 1'b1; req_address = 8'h44; req_write = 1'b0; req_data = '0; req_strobe = '0;
      rand_reg_side();
      set_idle_exp();
      step();
      req_valid = 1'b0; reg_active = 2'b01; reg_ready = 2'b00;
      set_busy_exp(8'h44, 1'b0, 32'h0, 32'h0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      rsp_ready = 1'b0;
      rand_reg_side();
      set_idle_exp();
      chk("reset_busy_reg_address", {56'd0, reg_address0}, 64'd0);
      idle(3);

      // Randomized traffic.
      for (int t = 0; t < 150; t++) begin
         do_txn(8'($urandom), 1'($urandom), $urandom, $urandom, 2'($urandom),
                $urandom_range(1, 6), $urandom, 2'($urandom_range(0, 1) * 2), $urandom_range(0, 3));
         idle($urandom_range(0, 2));
      end
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
